// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports and one clocked write port.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              we3;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [WIDTH-1:0]  wd3;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;

    modport master (output we3, a1, a2, a3, wd3, input rd1, rd2);
    modport slave  (input we3, a1, a2, a3, wd3, output rd1, rd2);
endinterface

// File: rtl/reg_file.sv
// RV32I integer register file: two async reads, one sync write, x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward wd3 to a read port addressing the register being written.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_file_if.slave   bus
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd1_c;
    logic [WIDTH-1:0] rd2_c;
    logic             wr_hit;

    assign wr_hit = bus.we3 && (bus.a3 != '0);

    // An unknown we3 falls through the if, so no entry is disturbed in simulation.
    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[bus.a3] = bus.wd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd1_c = (bus.a1 == '0) ? '0 : mem_q[bus.a1];
        rd2_c = (bus.a2 == '0) ? '0 : mem_q[bus.a2];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_hit && (bus.a1 == bus.a3)) begin
            rd1_c = bus.wd3;
        end
        if (rst_n && wr_hit && (bus.a2 == bus.a3)) begin
            rd2_c = bus.wd3;
        end
`endif
    end

    assign bus.rd1 = rd1_c;
    assign bus.rd2 = rd2_c;
endmodule
